herzel_coef_sched: RTL
======================

# herzel_coef_sched

Coefficient scheduler for the Goertzel (Herzel) filter bank inside `FourierTransform`. When the SPI `EN_CORDIC` register is written, this block walks all NF `FREQ_n` registers in turn. For each one it converts the frequency to a phase, shares the single CORDIC unit across the NF channels, and loads the resulting coefficient 2·cos(φ) into the matching Herzel channel. It reports `busy`, `done` and `err`, which feed the `STATUS` register (`STATUS_CORDIC_MSK` maps to `done`).

## Interface
- NF, 11: number of Herzel channels / frequency registers.
- PHASE_K, 42950: phase increment per frequency unit, round(2^32/NS) for NS = 100000; 2^32 = one full turn.
- TIMEOUT, 64: maximum cycles to wait for a CORDIC response.
- IW, $clog2(NF): channel index width.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse from the `EN_CORDIC` register write.
- abort  in  1  single-cycle pulse that cancels the current run.
- freq_sel  out  IW  index of the `FREQ_n` register being read.
- freq_data  in  32  unsigned `FREQ_n` value; a combinational function of `freq_sel`.
- cordic_req_valid  out  1  phase request to the CORDIC is valid.
- cordic_req_ready  in  1  CORDIC accepts the request.
- cordic_phase  out  32  unsigned phase, 2^32 = 2π.
- cordic_rsp_valid  in  1  CORDIC result is valid (single cycle).
- cordic_cos  in  32  signed cos(φ), Q2.30.
- coef_we  out  NF  one-hot, single-cycle coefficient write strobe.
- coef_data  out  32  signed coefficient 2·cos(φ), Q2.30.
- busy  out  1  a run is in progress.
- done  out  1  sticky; set when all NF coefficients have been written.
- err  out  1  sticky; set when a CORDIC response times out.

## Operation
- States: IDLE, FETCH, REQ, WAIT, WRITE. Register `idx` holds the current channel; `freq_sel = idx`.
- IDLE: `busy = 0`. When `start` is sampled, the block sets `idx = 0`, clears `done` and `err`, sets `busy`, and goes to FETCH.
- FETCH: samples `freq_data[idx]`.
  - If the value is 0, it loads `coef_data = 0x7FFF_FFFF` and goes to WRITE. The CORDIC is not used.
  - Otherwise it registers `cordic_phase = (freq_data × PHASE_K) mod 2^32`, keeping the low 32 bits of the 64-bit product, and goes to REQ.
- REQ: holds `cordic_req_valid = 1` with `cordic_phase` stable. On the cycle where `cordic_req_ready = 1`, the block goes to WAIT and clears the timeout counter.
  - Valid never drops before the handshake, except on `abort` or `rst`.
- WAIT: on `cordic_rsp_valid`, loads `coef_data = sat(cordic_cos << 1)` and goes to WRITE.
  - Saturation: `cordic_cos ≥ 0x4000_0000` gives 0x7FFF_FFFF. `cordic_cos < 0xC000_0000` gives 0x8000_0000. Any other value is shifted left by 1.
  - The counter increments every WAIT cycle. When it reaches TIMEOUT with no response, the block sets `err`, clears `busy`, leaves `done` at 0, writes nothing, and goes to IDLE.
- WRITE: `coef_we[idx] = 1` for exactly one cycle, with `coef_data` valid in that same cycle.
  - If `idx == NF-1`, the block sets `done`, clears `busy`, and goes to IDLE.
  - Otherwise it increments `idx` and goes to FETCH.
- `start` while `busy = 1` is ignored.
- `abort` in any state returns to IDLE on the next edge. It deasserts `cordic_req_valid` and `coef_we`, clears `busy` and `done`, and leaves `err` unchanged.
- `abort` and `start` in the same cycle: `abort` wins.
- `cordic_rsp_valid` outside WAIT is ignored.
- Coefficients written before an abort stay in the channels. The next `start` rewrites every channel.

## Timing
- Reset values: state IDLE, `idx = 0`, `busy = 0`, `done = 0`, `err = 0`, `cordic_req_valid = 0`, `cordic_phase = 0`, `coef_we = 0`, `coef_data = 0`, `freq_sel = 0`.
- `busy` rises on the edge that samples `start`.
- Cycles per channel:
  - Nonzero frequency: 1 (FETCH) + R (REQ, R ≥ 1 until ready) + L (WAIT, L ≥ 1) + 1 (WRITE). With ready tied high and L = 1, this is 4 cycles.
  - Zero frequency: 2 cycles.
- `done` rises and `busy` falls on the edge after the last WRITE cycle.
- A full run with NF = 11, always-ready CORDIC and L = 3 takes 11 × 6 = 66 cycles from `start` to `done`.
- Timeout: `err` is set TIMEOUT cycles after entry into WAIT.
- All outputs are registered. No combinational paths from inputs to outputs, except `freq_sel`, which comes from `idx`.

## Test plan
- Reset: assert `rst` mid-run in WAIT → all outputs return to their reset values asynchronously, and no `coef_we` pulse follows the release of reset.
- Full run: all 11 freqs = 1000, CORDIC ready = 1, latency 3, `cos = 0x2000_0000` → `cordic_phase = 0x028F_5D70`. Eleven `coef_we` pulses in order, bit 0 through bit 10, each with `coef_data = 0x4000_0000`. `done = 1` 66 cycles after `start`.
- Zero and saturation: FREQ_0 = 0, FREQ_1 → `cos = 0x4000_0000`, FREQ_2 → `cos = 0xC000_0000` → `coef_data` values 0x7FFF_FFFF (with no CORDIC request), 0x7FFF_FFFF and 0x8000_0000.
- Backpressure: `cordic_req_ready` low for 5 cycles → `cordic_req_valid` and `cordic_phase` stay stable for all 5 cycles, and exactly one handshake occurs.
- Timeout: CORDIC never responds on channel 3 → `err = 1` 64 cycles after entering WAIT. Only `coef_we` bits 0–2 pulsed, `busy = 0`, `done = 0`. The next `start` clears `err`.
- Abort and restart: `start` pulse while busy → ignored, run order unchanged. `abort` during REQ on channel 5 → `req_valid` low on the next cycle and `busy = 0`. A new `start` then rewrites channels 0 to 10.

Source files
------------

// File: rtl/herzel_coef_sched.sv
// rtl/herzel_coef_sched.sv - walks the FREQ_n registers and loads 2*cos(phase) into each Herzel channel
// via the shared CORDIC.
module herzel_coef_sched #(
  parameter int NF      = 11,
  parameter int PHASE_K = 42950,
  parameter int TIMEOUT = 64,
  parameter int IW      = $clog2(NF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic [IW-1:0] freq_sel,
  input  logic [31:0]   freq_data,
  output logic          cordic_req_valid,
  input  logic          cordic_req_ready,
  output logic [31:0]   cordic_phase,
  input  logic          cordic_rsp_valid,
  input  logic [31:0]   cordic_cos,
  output logic [NF-1:0] coef_we,
  output logic [31:0]   coef_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_REQ, S_WAIT, S_WRITE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            req_nxt, busy_nxt, done_nxt, err_nxt;
  logic [31:0]     phase_nxt, data_nxt, phase_calc, sat_cos;
  logic [NF-1:0]   we_nxt, we_onehot;

  assign freq_sel   = idx;
  // A 32-bit product keeps exactly the low word, i.e. the phase modulo one full turn.
  assign phase_calc = freq_data * 32'(PHASE_K);
  assign we_onehot  = {{(NF-1){1'b0}}, 1'b1} << idx;

  // Doubling overflows only when the two top bits differ; clamp those to the rails.
  always_comb begin
    sat_cos = {cordic_cos[30:0], 1'b0};
    if (cordic_cos[31:30] == 2'b01) sat_cos = 32'h7FFF_FFFF;
    if (cordic_cos[31:30] == 2'b10) sat_cos = 32'h8000_0000;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    req_nxt   = cordic_req_valid;
    phase_nxt = cordic_phase;
    we_nxt    = '0;
    data_nxt  = coef_data;
    busy_nxt  = busy;
    done_nxt  = done;
    err_nxt   = err;
    if (abort) begin
      state_nxt = S_IDLE;
      req_nxt   = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          idx_nxt   = '0;
          done_nxt  = 1'b0;
          err_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = S_FETCH;
        end
        S_FETCH: if (freq_data == 32'd0) begin
          data_nxt  = 32'h7FFF_FFFF;
          we_nxt    = we_onehot;
          state_nxt = S_WRITE;
        end else begin
          phase_nxt = phase_calc;
          req_nxt   = 1'b1;
          state_nxt = S_REQ;
        end
        S_REQ: if (cordic_req_ready) begin
          req_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = S_WAIT;
        end
        S_WAIT: if (cordic_rsp_valid) begin
          data_nxt  = sat_cos;
          we_nxt    = we_onehot;
          state_nxt = S_WRITE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
        S_WRITE: if (idx == IW'(NF - 1)) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = S_FETCH;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      idx              <= '0;
      cnt              <= '0;
      cordic_req_valid <= 1'b0;
      cordic_phase     <= '0;
      coef_we          <= '0;
      coef_data        <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      state            <= state_nxt;
      idx              <= idx_nxt;
      cnt              <= cnt_nxt;
      cordic_req_valid <= req_nxt;
      cordic_phase     <= phase_nxt;
      coef_we          <= we_nxt;
      coef_data        <= data_nxt;
      busy             <= busy_nxt;
      done             <= done_nxt;
      err              <= err_nxt;
    end
  end

endmodule
